// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: turns button pulses into the divider run level,
// counts divider ticks as BCD mm:ss, and drives a lap-freezable display value.
module stopwatch_ctrl #(
   parameter int unsigned MIN_LIMIT = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_ss,
   input  logic       btn_lap,
   input  logic       btn_clr,
   input  logic       tick,
   output logic       div_st,
   output logic       running,
   output logic       lap_act,
   output logic       ovf,
   output logic [3:0] disp_mt,
   output logic [3:0] disp_mo,
   output logic [3:0] disp_st,
   output logic [3:0] disp_so
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_LAP   = 2'd3
   } state_e;

   typedef struct packed {
      logic [3:0] mt;
      logic [3:0] mo;
      logic [3:0] st;
      logic [3:0] so;
   } tm_t;

   localparam logic [3:0] LIM_T = 4'(MIN_LIMIT / 10);
   localparam logic [3:0] LIM_O = 4'(MIN_LIMIT % 10);

   state_e state_q, state_d;
   tm_t    live_q, live_d;
   tm_t    snap_q, snap_d;
   tm_t    disp_q, disp_d;
   tm_t    live_inc;
   logic   wrap;
   logic   count_en;
   logic   div_st_q, div_st_d;
   logic   running_q, running_d;
   logic   lap_act_q, lap_act_d;
   logic   ovf_q, ovf_d;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; btn_clr outranks btn_ss, which outranks btn_lap
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (btn_ss && !btn_clr) state_d = S_RUN;
         end
         S_RUN: begin
            if (btn_clr)      state_d = S_IDLE;
            else if (btn_ss)  state_d = S_PAUSE;
            else if (btn_lap) state_d = S_LAP;
         end
         S_LAP: begin
            if (btn_clr)      state_d = S_IDLE;
            else if (btn_ss)  state_d = S_PAUSE;
            else if (btn_lap) state_d = S_RUN;
         end
         S_PAUSE: begin
            if (btn_clr)      state_d = S_IDLE;
            else if (btn_ss)  state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // BCD increment of the live count with wrap at MIN_LIMIT:59
   always_comb begin
      live_inc = live_q;
      wrap     = 1'b0;
      if (live_q.so != 4'd9) begin
         live_inc.so = live_q.so + 4'd1;
      end else begin
         live_inc.so = '0;
         if (live_q.st != 4'd5) begin
            live_inc.st = live_q.st + 4'd1;
         end else begin
            live_inc.st = '0;
            if (live_q.mt == LIM_T && live_q.mo == LIM_O) begin
               live_inc.mt = '0;
               live_inc.mo = '0;
               wrap        = 1'b1;
            end else if (live_q.mo != 4'd9) begin
               live_inc.mo = live_q.mo + 4'd1;
            end else begin
               live_inc.mo = '0;
               live_inc.mt = live_q.mt + 4'd1;
            end
         end
      end
   end

   // Count/snapshot update; a clear discards any coincident tick
   always_comb begin
      count_en = tick && (state_q == S_RUN || state_q == S_LAP);
      live_d   = live_q;
      snap_d   = snap_q;
      ovf_d    = 1'b0;
      if (btn_clr && state_q != S_IDLE) begin
         live_d = '0;
      end else if (count_en) begin
         live_d = live_inc;
         ovf_d  = wrap;
      end
      if (state_q == S_RUN && state_d == S_LAP) begin
         snap_d = live_d;
      end
   end

   // Output logic: levels follow the next state, display lags the count by one cycle
   always_comb begin
      div_st_d  = (state_d == S_RUN) || (state_d == S_LAP);
      running_d = div_st_d;
      lap_act_d = (state_d == S_LAP);
      disp_d    = (state_q == S_LAP) ? snap_q : live_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         live_q    <= '0;
         snap_q    <= '0;
         disp_q    <= '0;
         div_st_q  <= 1'b0;
         running_q <= 1'b0;
         lap_act_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         live_q    <= live_d;
         snap_q    <= snap_d;
         disp_q    <= disp_d;
         div_st_q  <= div_st_d;
         running_q <= running_d;
         lap_act_q <= lap_act_d;
         ovf_q     <= ovf_d;
      end
   end

   assign div_st  = div_st_q;
   assign running = running_q;
   assign lap_act = lap_act_q;
   assign ovf     = ovf_q;
   assign disp_mt = disp_q.mt;
   assign disp_mo = disp_q.mo;
   assign disp_st = disp_q.st;
   assign disp_so = disp_q.so;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: default instance plus a MIN_LIMIT=1
// instance sharing the same stimulus for the minute-wrap case.
module tb_stopwatch_ctrl;

   logic clk = 1'b0;
   logic rst, btn_ss, btn_lap, btn_clr, tick;

   logic       div_st0, running0, lap_act0, ovf0;
   logic [3:0] mt0, mo0, st0, so0;
   logic       div_st1, running1, lap_act1, ovf1;
   logic [3:0] mt1, mo1, st1, so1;

   int checks = 0;
   int errors = 0;
   int ovf_cnt0 = 0;
   int ovf_cnt1 = 0;

   always #5 clk = ~clk;

   stopwatch_ctrl #(.MIN_LIMIT(59)) dut (
      .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lap(btn_lap),
      .btn_clr(btn_clr), .tick(tick),
      .div_st(div_st0), .running(running0), .lap_act(lap_act0), .ovf(ovf0),
      .disp_mt(mt0), .disp_mo(mo0), .disp_st(st0), .disp_so(so0)
   );

   stopwatch_ctrl #(.MIN_LIMIT(1)) dut1 (
      .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lap(btn_lap),
      .btn_clr(btn_clr), .tick(tick),
      .div_st(div_st1), .running(running1), .lap_act(lap_act1), .ovf(ovf1),
      .disp_mt(mt1), .disp_mo(mo1), .disp_st(st1), .disp_so(so1)
   );

   always @(negedge clk) begin
      if (ovf0 === 1'b1) ovf_cnt0++;
      if (ovf1 === 1'b1) ovf_cnt1++;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0; tick = 1'b0;
   endtask

   task automatic press_ss();  btn_ss  = 1'b1; cyc(); btn_ss  = 1'b0; endtask
   task automatic press_lap(); btn_lap = 1'b1; cyc(); btn_lap = 1'b0; endtask
   task automatic press_clr(); btn_clr = 1'b1; cyc(); btn_clr = 1'b0; endtask

   task automatic ticks(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         cyc();
         tick = 1'b0;
         repeat (gap - 1) cyc();
      end
   endtask

   function automatic logic [15:0] d0();
      return {mt0, mo0, st0, so0};
   endfunction

   function automatic logic [15:0] d1();
      return {mt1, mo1, st1, so1};
   endfunction

   initial begin
      idle_in();
      rst = 1'b1;
      cyc(); cyc();
      rst = 1'b0;

      // Reset state
      chk("rst_div_st",  16'(div_st0),  16'h0);
      chk("rst_running", 16'(running0), 16'h0);
      chk("rst_lap_act", 16'(lap_act0), 16'h0);
      chk("rst_ovf",     16'(ovf0),     16'h0);
      chk("rst_disp",    d0(),          16'h0000);
      chk("rst_disp1",   d1(),          16'h0000);

      // 1: start and count 75 seconds
      press_ss();
      chk("t1_div_st",  16'(div_st0),  16'h1);
      chk("t1_running", 16'(running0), 16'h1);
      ticks(75, 5);
      chk("t1_disp",    d0(),          16'h0115);
      chk("t1_disp1",   d1(),          16'h0115);
      chk("t1_running2", 16'(running0), 16'h1);
      chk("t1_no_ovf",  16'(ovf_cnt0),  16'h0);

      // Clear from RUN
      press_clr();
      chk("clr_div_st", 16'(div_st0), 16'h0);
      cyc();
      chk("clr_disp",   d0(),         16'h0000);

      // 2: lap freeze and release
      press_ss();
      ticks(10, 3);
      chk("t2_disp10", d0(), 16'h0010);
      press_lap();
      chk("t2_lap_act", 16'(lap_act0), 16'h1);
      chk("t2_div_st",  16'(div_st0),  16'h1);
      ticks(5, 3);
      chk("t2_frozen",  d0(),          16'h0010);
      press_lap();
      chk("t2_lap_off", 16'(lap_act0), 16'h0);
      chk("t2_still",   d0(),          16'h0010);
      cyc();
      chk("t2_release", d0(),          16'h0015);

      // 3: stop coincident with tick at 00:09
      press_clr();
      press_ss();
      ticks(9, 2);
      chk("t3_disp09", d0(), 16'h0009);
      btn_ss = 1'b1; tick = 1'b1;
      cyc();
      idle_in();
      chk("t3_div_st",  16'(div_st0),  16'h0);
      chk("t3_running", 16'(running0), 16'h0);
      cyc();
      chk("t3_disp10",  d0(),          16'h0010);
      ticks(3, 3);
      chk("t3_paused",  d0(),          16'h0010);
      press_lap();
      chk("t3_lap_ign", 16'(lap_act0), 16'h0);
      press_ss();
      chk("t3_resume",  16'(div_st0),  16'h1);
      ticks(1, 3);
      chk("t3_disp11",  d0(),          16'h0011);

      // 5: clear + start/stop + tick together while in LAP
      press_lap();
      chk("t5_in_lap", 16'(lap_act0), 16'h1);
      btn_clr = 1'b1; btn_ss = 1'b1; tick = 1'b1;
      cyc();
      idle_in();
      chk("t5_div_st",  16'(div_st0),  16'h0);
      chk("t5_lap_act", 16'(lap_act0), 16'h0);
      chk("t5_running", 16'(running0), 16'h0);
      cyc();
      chk("t5_disp",    d0(),          16'h0000);
      chk("t5_no_ovf",  16'(ovf_cnt0), 16'h0);

      // 4: minute wrap with MIN_LIMIT=1
      press_ss();
      ticks(119, 2);
      chk("t4_disp159",  d1(),          16'h0159);
      chk("t4_pre_ovf",  16'(ovf_cnt1), 16'h0);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("t4_ovf_hi",   16'(ovf1),     16'h1);
      chk("t4_ovf0_lo",  16'(ovf0),     16'h0);
      cyc();
      chk("t4_ovf_lo",   16'(ovf1),     16'h0);
      chk("t4_disp000",  d1(),          16'h0000);
      chk("t4_disp200",  d0(),          16'h0200);
      chk("t4_ovf_once", 16'(ovf_cnt1), 16'h1);
      ticks(1, 3);
      chk("t4_disp001",  d1(),          16'h0001);

      // 6: reset mid-count with tick high
      press_clr();
      press_ss();
      ticks(42, 2);
      chk("t6_disp42", d0(), 16'h0042);
      rst = 1'b1; tick = 1'b1;
      cyc();
      rst = 1'b0; tick = 1'b0;
      chk("t6_div_st",  16'(div_st0),  16'h0);
      chk("t6_running", 16'(running0), 16'h0);
      chk("t6_lap_act", 16'(lap_act0), 16'h0);
      chk("t6_ovf",     16'(ovf0),     16'h0);
      chk("t6_disp",    d0(),          16'h0000);
      press_lap();
      press_clr();
      ticks(2, 2);
      chk("t6_idle_run", 16'(running0), 16'h0);
      chk("t6_idle_lap", 16'(lap_act0), 16'h0);
      chk("t6_idle_disp", d0(),         16'h0000);
      chk("t6_final_ovf", 16'(ovf_cnt0), 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Controller that sequences the shared seconds-tick divider for the lab stopwatch.
- Turns single-cycle button pulses into the divider's start/stop level.
- Counts divider ticks as BCD mm:ss and supplies a display value with lap-freeze.
- Sits between the debounced button pulses and the frequency divider on one side, and the 7-segment display driver on the other.

Parameters:
MIN_LIMIT, 59, highest minutes value before wrap; legal range 0..99.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high; clears all state
btn_ss  in  1  start/stop pulse, one cycle wide
btn_lap  in  1  lap/release pulse, one cycle wide
btn_clr  in  1  clear pulse, one cycle wide
tick  in  1  divider enable pulse, one cycle per second
div_st  out  1  divider run level; drives the divider start/stop input
running  out  1  high in RUN or LAP
lap_act  out  1  high in LAP; the display is frozen
ovf  out  1  one-cycle pulse on the MIN_LIMIT:59 -> 00:00 wrap
disp_mt  out  4  displayed minutes tens, BCD
disp_mo  out  4  displayed minutes ones, BCD
disp_st  out  4  displayed seconds tens, BCD (0..5)
disp_so  out  4  displayed seconds ones, BCD

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - Live count and snapshot = 00:00.
  - div_st=0, running=0, lap_act=0, ovf=0, all disp_* = 0.
- Reset mid-count overrides every other input in that cycle.
- States: IDLE, RUN, PAUSE, LAP. Transitions take effect at the edge where the pulse is sampled.
- Input priority each cycle: btn_clr > btn_ss > btn_lap.
- IDLE:
  - btn_ss -> RUN.
  - btn_lap and btn_clr are ignored; state stays IDLE.
- RUN:
  - btn_ss -> PAUSE.
  - btn_lap -> LAP; the snapshot register captures the live count at this edge, including any tick counted at the same edge.
  - btn_clr -> IDLE; live count is zeroed.
- LAP:
  - btn_lap -> RUN; the display returns to the live count.
  - btn_ss -> PAUSE; the display returns to the live count.
  - btn_clr -> IDLE; live count is zeroed.
- PAUSE:
  - btn_ss -> RUN.
  - btn_clr -> IDLE; live count is zeroed.
  - btn_lap is ignored.
- Output levels by next state:
  - div_st = 1 when the next state is RUN or LAP, else 0. It therefore updates on the same edge as the state register.
  - running and lap_act follow the same timing as div_st.
- Tick counting:
  - A tick is counted when the current state (before the edge) is RUN or LAP and tick=1.
  - The live count updates at that same edge.
  - A tick arriving in the cycle btn_ss stops RUN is still counted.
  - A tick in IDLE or PAUSE is dropped.
  - A tick coincident with btn_clr is discarded; count goes to 00:00.
- Counter arithmetic:
  - Seconds ones wraps 9 -> 0 and carries into seconds tens.
  - Seconds tens wraps 5 -> 0 and carries into minutes.
  - Minutes is a two-digit BCD value.
  - At MIN_LIMIT:59 plus one tick, the count becomes 00:00 and ovf=1 for exactly one cycle.
  - Counting continues after the wrap.
  - No BCD digit may ever hold a value above 9.
- Display:
  - disp_* shows the snapshot while in LAP.
  - In all other states it shows the live count.
  - Display latency is one cycle after a live-count update.
- Divider restart: the controller masks no ticks. Any tick received in RUN or LAP counts, including one arriving immediately after div_st rises.
- Simultaneous button pulses follow the priority rule; only one transition occurs per cycle.

Test Plan:
1. Reset, then btn_ss, then 75 tick pulses spaced 5 cycles apart -> div_st=1 one cycle after btn_ss; disp = 01:15; running=1; ovf never asserted.
2. In RUN at 00:10, btn_lap, then 5 ticks -> lap_act=1 and disp frozen at 00:10; btn_lap again -> disp=00:15 one cycle later.
3. In RUN, btn_ss coincident with tick at 00:09 -> state PAUSE, div_st=0, disp=00:10; 3 further ticks -> disp stays 00:10; btn_ss -> RUN resumes from 00:10.
4. MIN_LIMIT=1, count to 01:59, one tick -> disp 00:00, ovf high for exactly 1 cycle; next tick -> 00:01.
5. In LAP, btn_clr and btn_ss and tick in the same cycle -> IDLE, div_st=0, disp=00:00, lap_act=0, no ovf.
6. rst asserted in RUN at 00:42 with tick high -> next cycle: all outputs 0, state IDLE; btn_lap and btn_clr in IDLE -> no change.
